// File: rtl/axi_burst_addr_gen.sv
// AXI address-channel burst generator: splits a beat count into bursts that never
// cross a 4 KB boundary, with optional address wrap, credit limiting and clean abort.
module axi_burst_addr_gen #(
  parameter int ADDR_W          = 64,
  parameter int CNT_W           = 40,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              engine_start,
  input  logic [ADDR_W-1:0] source_address,
  input  logic [CNT_W-1:0]  total_beat_count,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic              wrap_mode,
  input  logic [3:0]        wrap_len,
  input  logic              abort,
  input  logic              resp_done,
  output logic [ADDR_W-1:0] axi_addr,
  output logic [7:0]        axi_len,
  output logic              axi_valid,
  input  logic              axi_ready,
  output logic              busy,
  output logic              addr_send_done,
  output logic [31:0]       bursts_issued,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_CALC, S_SEND, S_DRAIN, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, base_q;
  logic [CNT_W-1:0]    rem_q;
  logic [2:0]          size_q;
  logic [7:0]          len_q;
  logic                wrap_q;
  logic [3:0]          wrap_len_q;
  logic [8:0]          burst_q, burst_d;
  logic [8:0]          outst_q;
  logic                abort_q, abort_eff;
  logic [2:0]          size_fix;
  logic [ADDR_W-1:0]   low_mask, step, sum, win_mask, next_addr;
  logic [12:0]         to4k;
  logic                hs;

  // Handshake: a burst is transferred on any cycle where axi_valid && axi_ready;
  // once raised, axi_valid and axi_addr/axi_len hold until that cycle.
  assign axi_valid      = (state_q == S_SEND) && (outst_q < 9'(MAX_OUTSTANDING));
  assign hs             = axi_valid && axi_ready;
  assign busy           = (state_q != S_IDLE);
  assign addr_send_done = (state_q == S_DONE);
  assign state_dbg      = state_q;
  assign abort_eff      = abort_q || abort;

  assign size_fix = (size < 3'd2) ? 3'd7 : size;
  assign low_mask = (ADDR_W'(1) << size_fix) - ADDR_W'(1);

  // Wide enough that 4096 >> size is exact for every legal size.
  assign to4k = (13'd4096 >> size_q) - ({1'b0, addr_q[11:0]} >> size_q);

  always_comb begin
    burst_d = {1'b0, len_q} + 9'd1;
    if (to4k < {4'd0, burst_d}) burst_d = to4k[8:0];
    if (rem_q < CNT_W'(burst_d)) burst_d = rem_q[8:0];
  end

  // In wrap mode everything above the window comes from the start address.
  assign step      = ADDR_W'(burst_q) << size_q;
  assign sum       = addr_q + step;
  assign win_mask  = (ADDR_W'(1) << (5'd12 + 5'(wrap_len_q))) - ADDR_W'(1);
  assign next_addr = wrap_q ? ((sum & win_mask) | (base_q & ~win_mask)) : sum;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (engine_start) state_d = S_INIT;
      S_INIT: begin
        if (rem_q == '0)    state_d = S_DONE;
        else if (abort_eff) state_d = S_DRAIN;
        else                state_d = S_CALC;
      end
      S_CALC:  state_d = abort_eff ? S_DRAIN : S_SEND;
      S_SEND: begin
        if (hs)
          state_d = ((rem_q == CNT_W'(burst_q)) || abort_eff) ? S_DRAIN : S_CALC;
        else if (!axi_valid && abort_eff)
          state_d = S_DRAIN;
      end
      S_DRAIN: if (outst_q == 9'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      base_q        <= '0;
      rem_q         <= '0;
      size_q        <= '0;
      len_q         <= '0;
      wrap_q        <= 1'b0;
      wrap_len_q    <= '0;
      burst_q       <= '0;
      outst_q       <= '0;
      abort_q       <= 1'b0;
      axi_addr      <= '0;
      axi_len       <= '0;
      bursts_issued <= '0;
    end else begin
      state_q <= state_d;

      if (hs && !resp_done)
        outst_q <= outst_q + 9'd1;
      else if (!hs && resp_done && (outst_q != 9'd0))
        outst_q <= outst_q - 9'd1;

      if ((state_q == S_IDLE) && engine_start) begin
        addr_q        <= source_address & ~low_mask;
        base_q        <= source_address & ~low_mask;
        rem_q         <= total_beat_count;
        size_q        <= size_fix;
        len_q         <= len;
        wrap_q        <= wrap_mode;
        wrap_len_q    <= wrap_len;
        abort_q       <= 1'b0;
        bursts_issued <= '0;
      end else if (abort && ((state_q == S_INIT) || (state_q == S_CALC) || (state_q == S_SEND))) begin
        abort_q <= 1'b1;
      end

      if (state_q == S_CALC) begin
        burst_q  <= burst_d;
        axi_addr <= addr_q;
        axi_len  <= 8'(burst_d - 9'd1);
      end

      if (hs) begin
        addr_q        <= next_addr;
        rem_q         <= rem_q - CNT_W'(burst_q);
        bursts_issued <= bursts_issued + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Bench for axi_burst_addr_gen: directed cases plus random transfers, scoreboarded
// against a plain-arithmetic burst model; a responder echoes completions.
module tb_axi_burst_addr_gen;

  logic        clk, rst, engine_start, wrap_mode, abort, resp_done;
  logic [63:0] source_address, axi_addr;
  logic [39:0] total_beat_count;
  logic [2:0]  size, state_dbg;
  logic [7:0]  len, axi_len;
  logic [3:0]  wrap_len;
  logic        axi_valid, axi_ready, busy, addr_send_done;
  logic [31:0] bursts_issued;

  axi_burst_addr_gen #(.ADDR_W(64), .CNT_W(40), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .engine_start(engine_start), .source_address(source_address),
    .total_beat_count(total_beat_count), .size(size), .len(len), .wrap_mode(wrap_mode),
    .wrap_len(wrap_len), .abort(abort), .resp_done(resp_done), .axi_addr(axi_addr),
    .axi_len(axi_len), .axi_valid(axi_valid), .axi_ready(axi_ready), .busy(busy),
    .addr_send_done(addr_send_done), .bursts_issued(bursts_issued), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [71:0] exp_q[$];
  logic [31:0] done_q[$];
  int          total_n = 0, bad_n = 0;
  int          hs_seen = 0, done_seen = 0;
  int          rsp_q[$];
  int          rsp_mode = 1, manual_req = 0, manual_ack = 0;
  int          ready_mode = 0;
  logic        ready_force = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] want);
    total_n++;
    if (act !== want) begin
      bad_n++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: walk the transfer with plain arithmetic, push every expected burst.
  task automatic model(input logic [63:0] a0, input logic [39:0] tot, input logic [2:0] sz,
                       input logic [7:0] ln, input logic wm, input logic [3:0] wl, output int nb);
    logic [63:0] a, base, bytes, win;
    logic [39:0] rem;
    int s, b, to4k;
    s = (sz < 2) ? 7 : int'(sz);
    bytes = 64'd1 << s;
    a = a0 - (a0 % bytes);
    base = a;
    rem = tot;
    nb = 0;
    while (rem != 0) begin
      to4k = int'((64'd4096 - (a % 64'd4096)) / bytes);
      b = int'(ln) + 1;
      if (to4k < b) b = to4k;
      if (rem < 40'(b)) b = int'(rem);
      exp_q.push_back({a, 8'(b - 1)});
      nb++;
      a = a + 64'(b) * bytes;
      if (wm) begin
        win = 64'd1 << (12 + int'(wl));
        a = base - (base % win) + (a % win);
      end
      rem = rem - 40'(b);
    end
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (axi_valid && axi_ready) begin
        hs_seen++;
        if (exp_q.size() == 0) begin
          total_n++; bad_n++;
          $display("FAIL unexpected_burst: got addr %h len %0d, expected none", axi_addr, axi_len);
        end else begin
          check("burst", {axi_addr, axi_len}, exp_q.pop_front());
        end
      end
      if (addr_send_done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          total_n++; bad_n++;
          $display("FAIL unexpected_done: got done pulse, expected none");
        end else begin
          check("bursts_issued", 72'(bursts_issued), 72'(done_q.pop_front()));
        end
        check("done_after_last_resp", 72'(rsp_q.size()), 72'd0);
      end
    end
  end

  // ---------------- responder (owns resp_done) ----------------
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (rst) rsp_q.delete();
      else begin
        if (axi_valid && axi_ready) rsp_q.push_back(cyc);
        case (rsp_mode)
          0: if (manual_req != manual_ack) begin
               manual_ack++;
               resp_done = 1'b1;
               if (rsp_q.size() > 0) void'(rsp_q.pop_front());
             end
          1: if (rsp_q.size() > 0 && cyc >= rsp_q[0] + 1 && $urandom_range(0, 2) == 0) begin
               void'(rsp_q.pop_front());
               resp_done = 1'b1;
             end
          default: if (rsp_q.size() > 0 && cyc >= rsp_q[0] + 2) begin
               void'(rsp_q.pop_front());
               resp_done = 1'b1;
             end
        endcase
      end
    end
  end

  // ---------------- ready driver (owns axi_ready) ----------------
  initial begin
    axi_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      axi_ready = (ready_mode != 0) ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // ---------------- driver tasks ----------------
  int ndone = 0;

  task automatic setup(input logic [63:0] a, input logic [39:0] t, input logic [2:0] sz,
                       input logic [7:0] ln, input logic wm, input logic [3:0] wl);
    source_address = a; total_beat_count = t; size = sz; len = ln;
    wrap_mode = wm; wrap_len = wl;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 engine_start = 1'b1;
    @(posedge clk); #1 engine_start = 1'b0;
  endtask

  task automatic run_model(input logic [63:0] a, input logic [39:0] t, input logic [2:0] sz,
                           input logic [7:0] ln, input logic wm, input logic [3:0] wl);
    int nb;
    setup(a, t, sz, ln, wm, wl);
    model(a, t, sz, ln, wm, wl, nb);
    done_q.push_back(32'(nb));
    pulse_start();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    ndone++;
    while (done_seen < ndone && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_done_seen"}, 72'(done_seen >= ndone), 72'd1);
    check({name, "_all_bursts"}, 72'(exp_q.size()), 72'd0);
    check({name, "_idle_after"}, 72'(busy), 72'd0);
    if (done_seen < ndone) begin
      done_seen = ndone;
      exp_q.delete();
      done_q.delete();
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!axi_valid && n < 200);
    check({name, "_valid_seen"}, 72'(axi_valid), 72'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] a0;
    logic [7:0]  l0;
    int          h0, vcnt, first, stable;

    rst = 1'b1; engine_start = 1'b0; abort = 1'b0;
    setup(64'd0, 40'd0, 3'd0, 8'd0, 1'b0, 4'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {axi_addr, axi_len},  72'd0);
    check("reset_status", {68'd0, axi_valid, busy, addr_send_done, 1'b0}, 72'd0);
    check("reset_count", 72'(bursts_issued), 72'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 4 KB split, with start latency
    ready_force = 1'b1; rsp_mode = 1;
    setup(64'h1000_0F00, 40'd40, 3'd5, 8'd15, 1'b0, 4'd0);
    exp_q.push_back({64'h1000_0F00, 8'd7});
    exp_q.push_back({64'h1000_1000, 8'd15});
    exp_q.push_back({64'h1000_1200, 8'd15});
    done_q.push_back(32'd3);
    pulse_start();
    check("busy_in_init", 72'(busy), 72'd1);
    @(posedge clk); @(posedge clk); #1;
    check("start_latency_valid", 72'(axi_valid), 72'd1);
    wait_done("split4k");

    // wrap
    setup(64'h2000_0F80, 40'd4, 3'd7, 8'd1, 1'b1, 4'd0);
    exp_q.push_back({64'h2000_0F80, 8'd0});
    exp_q.push_back({64'h2000_0000, 8'd1});
    exp_q.push_back({64'h2000_0100, 8'd0});
    done_q.push_back(32'd3);
    pulse_start();
    wait_done("wrap");

    // stray completion while nothing is outstanding must be ignored
    rsp_mode = 0;
    @(posedge clk); #1 manual_req++;
    repeat (3) @(posedge clk);

    // credit stall with two credits
    setup(64'd0, 40'd64, 3'd5, 8'd15, 1'b0, 4'd0);
    exp_q.push_back({64'h0, 8'd15});
    exp_q.push_back({64'h200, 8'd15});
    exp_q.push_back({64'h400, 8'd15});
    exp_q.push_back({64'h600, 8'd15});
    done_q.push_back(32'd4);
    h0 = hs_seen;
    pulse_start();
    for (int i = 0; i < 100 && hs_seen < h0 + 2; i++) @(negedge clk);
    check("credit_two_issued", 72'(hs_seen - h0), 72'd2);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (axi_valid) vcnt++;
    end
    check("credit_stall_no_valid", 72'(vcnt), 72'd0);
    @(posedge clk); #1 manual_req++;
    @(negedge clk);
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (axi_valid && first == 0) first = k;
    end
    check("credit_release_latency", 72'(first >= 1 && first <= 2), 72'd1);
    rsp_mode = 1;
    wait_done("credit");

    // abort under back-pressure
    ready_force = 1'b0;
    setup(64'h3000_0000, 40'd100, 3'd3, 8'd7, 1'b0, 4'd0);
    exp_q.push_back({64'h3000_0000, 8'd7});
    done_q.push_back(32'd1);
    pulse_start();
    wait_valid("abort");
    a0 = axi_addr; l0 = axi_len;
    check("abort_first_burst", {a0, l0}, {64'h3000_0000, 8'd7});
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(axi_valid && axi_addr == a0 && axi_len == l0)) stable = 0;
    end
    check("abort_hold_stable", 72'(stable), 72'd1);
    @(posedge clk); #1 ready_force = 1'b1;
    wait_done("abort");

    // zero-length transfer: done two cycles after start
    setup(64'h4000_0000, 40'd0, 3'd4, 8'd3, 1'b0, 4'd0);
    done_q.push_back(32'd0);
    pulse_start();
    check("zero_no_early_done", 72'(addr_send_done), 72'd0);
    @(posedge clk); #1;
    check("zero_done_latency", 72'(addr_send_done), 72'd1);
    wait_done("zero");

    // completion coincident with every handshake
    rsp_mode = 2;
    run_model(64'h5000_0000, 40'd40, 3'd2, 8'd3, 1'b0, 4'd0);
    wait_done("coincident");
    rsp_mode = 1;

    // reset mid-transfer, then a normal run
    ready_force = 1'b0;
    setup(64'h6000_0100, 40'd50, 3'd4, 8'd7, 1'b0, 4'd0);
    exp_q.push_back({64'h6000_0100, 8'd7});
    pulse_start();
    wait_valid("midrst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {axi_addr, axi_len}, 72'd0);
    check("midrst_status", {68'd0, axi_valid, busy, addr_send_done, 1'b0}, 72'd0);
    check("midrst_count", 72'(bursts_issued), 72'd0);
    exp_q.delete();
    rst = 1'b0;
    ready_force = 1'b1;
    run_model(64'h1000_0F00, 40'd40, 3'd5, 8'd15, 1'b0, 4'd0);
    wait_done("after_rst");

    // random transfers
    ready_mode = 1;
    for (int r = 0; r < 10; r++) begin
      rsp_mode = $urandom_range(1, 2);
      run_model({$urandom, $urandom}, 40'($urandom_range(0, 150)), 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      wait_done("random");
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
